// File: rtl/exec_sequencer_pkg.sv
// rtl/exec_sequencer_pkg.sv - shared state codes, stop causes and drain default for the exec sequencer
package exec_sequencer_pkg;

  localparam int DRAIN_CYCLES_DEF = 4;

  // HALTED needs the extra bit; the external state code folds it onto DRAIN's code
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_USER  = 2'd0,
    CAUSE_HALT  = 2'd1,
    CAUSE_BREAK = 2'd2,
    CAUSE_LIMIT = 2'd3
  } stop_cause_e;

  function automatic logic [1:0] state_code(input logic [2:0] s);
    return (s == ST_HALTED) ? 2'd3 : s[1:0];
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - control/status bundle between the debug front end and the exec sequencer
interface exec_sequencer_if;
  logic        exec_pulse;
  logic        mode_step;
  logic        halt_in;
  logic        stall_req;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic [15:0] pc;
  logic [15:0] run_limit;
  logic        ce_fetch;
  logic        ce_pipe;
  logic [1:0]  state;
  logic [1:0]  stop_cause;
  logic [31:0] cycle_count;
  logic        busy;

  modport master (
    output exec_pulse, mode_step, halt_in, stall_req, bp_en, bp_addr, pc, run_limit,
    input  ce_fetch, ce_pipe, state, stop_cause, cycle_count, busy
  );

  modport slave (
    input  exec_pulse, mode_step, halt_in, stall_req, bp_en, bp_addr, pc, run_limit,
    output ce_fetch, ce_pipe, state, stop_cause, cycle_count, busy
  );
endinterface

// File: rtl/exec_sequencer_sat_counter32.sv
// rtl/exec_sequencer_sat_counter32.sv - 32-bit enabled counter that sticks at all-ones
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (en && count != 32'hFFFF_FFFF)
      count <= count + 32'd1;
  end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - run/step/drain/halt sequencer producing pipeline clock enables
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input logic             clk,
  input logic             rst_n,
  exec_sequencer_if.slave bus
);

  localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES - 1);

  seq_state_e  st;
  stop_cause_e cause;
  logic [15:0] run_cnt;
  logic [15:0] drain_cnt;
  logic        bp_armed;

  logic        fetch_st;
  logic        break_hit;
  logic        limit_hit;
  logic        user_hit;
  logic        stop_hit;
  stop_cause_e stop_sel;

  assign fetch_st        = (st == ST_RUN) || (st == ST_STEP);
  assign bus.ce_fetch    = fetch_st && !bus.stall_req;
  assign bus.ce_pipe     = fetch_st || (st == ST_DRAIN);
  assign bus.busy        = bus.ce_pipe;
  assign bus.state       = state_code(st);
  assign bus.stop_cause  = cause;

  assign break_hit = bus.bp_en && (bus.pc == bus.bp_addr) && bus.ce_fetch && bp_armed;
  assign limit_hit = (st == ST_RUN) && (bus.run_limit != 16'd0) &&
                     (run_cnt == bus.run_limit - 16'd1);
  assign user_hit  = (st == ST_RUN) && bus.exec_pulse;

  always_comb begin
    stop_hit = 1'b1;
    stop_sel = CAUSE_USER;
    if (bus.halt_in)     stop_sel = CAUSE_HALT;
    else if (break_hit)  stop_sel = CAUSE_BREAK;
    else if (limit_hit)  stop_sel = CAUSE_LIMIT;
    else if (user_hit)   stop_sel = CAUSE_USER;
    else                 stop_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      cause     <= CAUSE_USER;
      run_cnt   <= '0;
      drain_cnt <= '0;
      bp_armed  <= 1'b0;
    end else begin
      // breakpoint re-arms only once the PC has moved off the breakpoint address
      if (bus.pc != bus.bp_addr)
        bp_armed <= 1'b1;
      else if (break_hit)
        bp_armed <= 1'b0;

      case (st)
        ST_IDLE: begin
          if (bus.exec_pulse) begin
            if (bus.mode_step) begin
              st <= ST_STEP;
            end else begin
              st      <= ST_RUN;
              run_cnt <= '0;
            end
          end
        end
        ST_RUN, ST_STEP: begin
          if (st == ST_RUN)
            run_cnt <= run_cnt + 16'd1;
          if (fetch_st && stop_hit) begin
            st        <= ST_DRAIN;
            cause     <= stop_sel;
            drain_cnt <= DRAIN_LOAD;
          end else if (st == ST_STEP) begin
            st <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 16'd0)
            st <= (cause == CAUSE_HALT) ? ST_HALTED : ST_IDLE;
          else
            drain_cnt <= drain_cnt - 16'd1;
        end
        ST_HALTED: st <= ST_HALTED;
        default:   st <= ST_IDLE;
      endcase
    end
  end

  sat_counter32 u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.ce_pipe),
    .count (bus.cycle_count)
  );

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 4, number of pipeline-only cycles after fetch stops.
REQ-002 The block SHALL provide these ports (name  direction  width  meaning):
  clk  in  1  pipeline clock
  rst_n  in  1  reset, asynchronous, active-low
  exec_pulse  in  1  debounced one-cycle exec button pulse
  mode_step  in  1  1 = single-step mode, 0 = free run
  halt_in  in  1  halt instruction decoded in ID stage
  stall_req  in  1  load-use hazard; hold fetch this cycle
  bp_en  in  1  PC breakpoint enable
  bp_addr  in  16  breakpoint PC
  pc  in  16  current fetch PC
  run_limit  in  16  max RUN cycles; 0 = unlimited
  ce_fetch  out  1  PC/IR update enable
  ce_pipe  out  1  ID/EX/MEM/WB register enable
  state  out  2  current state code
  stop_cause  out  2  reason for last stop
  cycle_count  out  32  total enabled pipeline cycles
  busy  out  1  high in RUN, STEP or DRAIN

Function
REQ-003 States SHALL be IDLE, RUN, STEP, DRAIN, HALTED; state is registered.
REQ-004 ce_pipe SHALL be 1 in RUN, STEP and DRAIN, else 0; decoded from the registered state.
REQ-005 ce_fetch SHALL be 1 only in RUN or STEP with stall_req=0; 0 in DRAIN, IDLE and HALTED.
REQ-006 IDLE: exec_pulse with mode_step=0 SHALL go to RUN next cycle; with mode_step=1 SHALL go to STEP; no pulse holds IDLE.
REQ-007 STEP SHALL last exactly one cycle, then return to IDLE unless a stop condition (REQ-009) goes to DRAIN.
REQ-008 RUN SHALL clear an internal 16-bit run counter on entry and increment it each RUN cycle.
REQ-009 Stop conditions evaluated in RUN/STEP, priority high to low:
  - halt_in=1: cause HALT (code 1).
  - bp_en=1, pc==bp_addr, ce_fetch=1: cause BREAK (code 2).
  - run_limit!=0 and run counter == run_limit-1 (RUN only): cause LIMIT (code 3).
  - exec_pulse=1 in RUN: cause USER (code 0).
  Any of these SHALL go to DRAIN next cycle, latch stop_cause, and load the drain counter.
REQ-010 A BREAK stop SHALL fire at most once per PC value; re-entry to RUN with pc still equal to bp_addr SHALL NOT re-trigger until pc changes.
REQ-011 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then go to HALTED if cause=HALT, else to IDLE.
REQ-012 exec_pulse SHALL be ignored in DRAIN and HALTED; HALTED exits only through reset.
REQ-013 cycle_count SHALL increment each cycle ce_pipe=1 and saturate at 0xFFFFFFFF.
REQ-014 Latency: exec_pulse sampled in cycle n sets ce_pipe=1 in cycle n+1.
REQ-015 With run_limit=L!=0 and no other stop, RUN SHALL last exactly L cycles.
REQ-016 Simultaneous stop conditions SHALL record only the highest-priority cause.

Reset
REQ-017 Reset SHALL force state=IDLE, ce_fetch=0, ce_pipe=0, busy=0, stop_cause=0, cycle_count=0, and clear the run, drain and breakpoint-armed registers.
REQ-018 Reset asserted in mid-RUN or mid-DRAIN SHALL take effect immediately, without completing the drain.

Structure
REQ-019 State codes (IDLE=0, RUN=1, STEP=2, DRAIN=3; HALTED uses internal extra bit, state output reports 3 with busy=0), stop-cause codes and the DRAIN_CYCLES default SHALL live in a shared package.
REQ-020 The 32-bit saturating cycle counter SHALL be one sub-module, sat_counter32, with enable and async reset; all other logic is in exec_sequencer.

Verification
REQ-021 mode_step=0, run_limit=5, pulse exec -> ce_pipe high 5+4=9 cycles, ce_fetch high 5 cycles, stop_cause=3, final state IDLE, cycle_count=9.
REQ-022 mode_step=1, three exec pulses spaced 3 cycles apart -> three single-cycle ce_fetch pulses, each followed by 0 drain, cycle_count=3.
REQ-023 Free run, halt_in=1 on cycle 7 of RUN -> ce_fetch low from cycle 8, ce_pipe low after 4 drain cycles, state HALTED, later exec pulses ignored.
REQ-024 bp_en=1, bp_addr=0x0010, pc steps 0x000C..0x0010 -> stop_cause=2, drain then IDLE; re-exec with pc=0x0010 continues without re-break.
REQ-025 Free run, stall_req high 2 cycles -> ce_fetch=0 those cycles, ce_pipe stays 1; halt_in and breakpoint same cycle -> stop_cause=1.
REQ-026 rst_n low in mid-DRAIN -> outputs at reset values immediately; cycle_count=0.
